// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the two-port memory arbiter:
//     - FSM state encodings (IDLE, WRITE, READ, RESP)
//     - maximum supported read latency and latency counter width
//     - helper used by the elaboration-time latency range check
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Read latency limits; the counter must be able to hold MEM_ARB_MAX_LAT
  localparam int unsigned MEM_ARB_MAX_LAT = 7;
  localparam int unsigned LAT_CNT_W       = 3;

  function automatic logic lat_in_range(input int unsigned lat);
    return (lat >= 1) && (lat <= MEM_ARB_MAX_LAT);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// mem_arbiter_rr_arb2 (rr_arb2)
//   Purely combinational 2-way picker. The last-winner register is owned by
//   the caller so this block has no state.
//
// Ports
//   i_req[1:0]   request per port
//   i_last_win   port that won the previous grant
//   i_fixed      1 = port 0 always wins a tie, 0 = alternate on ties
//   o_gnt[1:0]   one-hot grant (all zero when nobody requests)
//   o_win        index of the selected port
// ----------------------------------------------------------------------------
module mem_arbiter_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_win,
  input  logic       i_fixed,
  output logic [1:0] o_gnt,
  output logic       o_win
);

  logic w_win;

  always_comb begin
    // A single requester always wins; only a tie consults the policy.
    if (&i_req) begin
      w_win = i_fixed ? 1'b0 : ~i_last_win;
    end else begin
      w_win = i_req[1];
    end

    o_gnt = 2'b00;
    if (|i_req) begin
      o_gnt = w_win ? 2'b10 : 2'b01;
    end
    o_win = w_win;
  end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one unified instruction/data memory between port 0 (mips core)
//   and port 1 (loader/debug DMA). One single-word transaction is granted at
//   a time and sequenced into a memory with a fixed read latency. Read data
//   is registered and returned to the winning port with a one-cycle valid.
//
// Parameters
//   WIDTH       address/data width
//   RD_LAT      cycles from mem_re to valid mem_rdata (1..7)
//   PRIO_FIXED  0 = round-robin on contention, 1 = port 0 always wins
//
// Ports
//   i_clk, i_reset          clock; asynchronous active-low reset
//   i_mN_req/we/adr/wdata   port N command, held stable until o_mN_gnt
//   o_mN_gnt                port N grant pulse (command captured at this edge)
//   o_mN_rvalid             port N read data valid pulse
//   o_rdata                 registered read data shared by both ports
//   o_mem_adr/o_mem_wdata   registered memory address / write data
//   o_mem_we/o_mem_re       one-cycle memory write / read strobes
//   i_mem_rdata             memory read data, valid RD_LAT cycles after mem_re
//   o_busy                  high whenever a transaction is in flight
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  // port 0
  input  logic             i_m0_req,
  input  logic             i_m0_we,
  input  logic [WIDTH-1:0] i_m0_adr,
  input  logic [WIDTH-1:0] i_m0_wdata,
  output logic             o_m0_gnt,
  output logic             o_m0_rvalid,
  // port 1
  input  logic             i_m1_req,
  input  logic             i_m1_we,
  input  logic [WIDTH-1:0] i_m1_adr,
  input  logic [WIDTH-1:0] i_m1_wdata,
  output logic             o_m1_gnt,
  output logic             o_m1_rvalid,
  // shared read data
  output logic [WIDTH-1:0] o_rdata,
  // memory side
  output logic [WIDTH-1:0] o_mem_adr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic             o_mem_we,
  output logic             o_mem_re,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_busy
);

  // Elaboration-time guard on the latency counter range
  if (!lat_in_range(RD_LAT)) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT must be in 1..%0d", MEM_ARB_MAX_LAT);
  end

  localparam logic [LAT_CNT_W-1:0] LAT_END = LAT_CNT_W'(RD_LAT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [1:0]           w_state_d;
  logic                 r_last_win;
  logic                 r_win;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic [WIDTH-1:0]     r_rdata;
  logic [WIDTH-1:0]     r_mem_adr;
  logic [WIDTH-1:0]     r_mem_wdata;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [1:0]       w_arb_gnt;
  logic             w_arb_win;
  logic             w_idle;
  logic             w_take;
  logic             w_sel_we;
  logic [WIDTH-1:0] w_sel_adr;
  logic [WIDTH-1:0] w_sel_wdata;
  logic             w_in_read;
  logic             w_lat_done;

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .i_req      ({i_m1_req, i_m0_req}),
    .i_last_win (r_last_win),
    .i_fixed    (PRIO_FIXED != 0),
    .o_gnt      (w_arb_gnt),
    .o_win      (w_arb_win)
  );

  assign w_idle = (r_state == IDLE);
  // Grants only exist in IDLE, so a transaction can never be re-granted while
  // it is still being sequenced.
  assign w_take = w_idle && (|w_arb_gnt);

  assign w_sel_we    = w_arb_win ? i_m1_we    : i_m0_we;
  assign w_sel_adr   = w_arb_win ? i_m1_adr   : i_m0_adr;
  assign w_sel_wdata = w_arb_win ? i_m1_wdata : i_m0_wdata;

  // lat_cnt is 0 in the mem_re cycle, then counts 1..RD_LAT; the data is
  // captured in the cycle where it reaches RD_LAT.
  assign w_in_read  = (r_state == READ);
  assign w_lat_done = (r_lat_cnt == LAT_END);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_d = w_sel_we ? WRITE : READ;
        end
      end
      WRITE: w_state_d = IDLE;
      READ: begin
        if (w_lat_done) begin
          w_state_d = RESP;
        end
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_last_win  <= 1'b1;  // port 0 wins the first tie after reset
      r_win       <= 1'b0;
      r_lat_cnt   <= '0;
      r_rdata     <= '0;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_state_d;

      if (w_take) begin
        r_win       <= w_arb_win;
        r_last_win  <= w_arb_win;
        r_mem_adr   <= w_sel_adr;
        r_mem_wdata <= w_sel_wdata;
        r_lat_cnt   <= '0;
      end else if (w_in_read && !w_lat_done) begin
        r_lat_cnt <= r_lat_cnt + LAT_CNT_W'(1);
      end

      if (w_in_read && w_lat_done) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_m0_gnt    = w_idle && w_arb_gnt[0];
  assign o_m1_gnt    = w_idle && w_arb_gnt[1];
  assign o_m0_rvalid = (r_state == RESP) && !r_win;
  assign o_m1_rvalid = (r_state == RESP) && r_win;

  assign o_rdata     = r_rdata;
  assign o_mem_adr   = r_mem_adr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = (r_state == WRITE);
  // Strobe only in the first READ cycle
  assign o_mem_re    = w_in_read && (r_lat_cnt == '0);
  assign o_busy      = !w_idle;

endmodule
